// File: rtl/find_collect_pkg.sv
// -----------------------------------------------------------------------------
// find_collect_pkg
// Shared definitions for the find-result collector: result entry sizing,
// timestamp width and the scanner action encoding.
//
// Configuration macro: FIND_COLLECT_TIMESTAMP_EN
//   defined   -> every FIFO entry carries an extra 32-bit capture timestamp
//   undefined -> entry = {unit, energy, sequence}
// -----------------------------------------------------------------------------
package find_collect_pkg;

  // Width of the free-running cycle counter used for capture timestamps.
  localparam int TS_W = 32;

`ifdef FIND_COLLECT_TIMESTAMP_EN
  localparam int ENTRY_EXTRA_W = TS_W;
`else
  localparam int ENTRY_EXTRA_W = 0;
`endif

  // Entry layout, LSB first: sequence, energy, unit index, [timestamp].
  function automatic int entry_width(input int unit_w, input int e_w,
                                     input int seq_w);
    return unit_w + e_w + seq_w + ENTRY_EXTRA_W;
  endfunction

  // What the scanner does with the unit it is pointing at this cycle.
  typedef enum logic [1:0] {
    SCAN_SKIP  = 2'd0,  // nothing pending, move on
    SCAN_PUSH  = 2'd1,  // pending and room in the FIFO
    SCAN_STALL = 2'd2   // pending but FIFO full, hold position
  } scan_act_e;

endpackage

// File: rtl/find_result_fifo.sv
// -----------------------------------------------------------------------------
// find_result_fifo
// Show-ahead synchronous FIFO. The head entry is presented combinationally
// from storage; head_data reads as zero while the FIFO is empty.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, push_data write request (ignored when full)
//   pop             read request (ignored when empty)
//   head_data       oldest entry
//   empty, full     status from the registered occupancy
//   count           occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module find_result_fifo #(
  parameter int DEPTH = 4,   // power of two, >= 2
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q,  count_d;
  logic             push_ok, pop_ok;

  assign empty   = (count_q == '0);
  // Full comes from the registered count, so a same-cycle pop does not make
  // room for a push.
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign count   = count_q;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments and a synchronous reset
  // tested inside the clocked block.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // what is valid, and the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/find_collect.sv
// -----------------------------------------------------------------------------
// find_collect
// Collects results from PARALLEL_UNITS find units. A rising edge on a unit's
// done level captures its sequence/energy and marks it pending. A scanner
// visits one unit per cycle and moves pending results into a show-ahead FIFO
// for software readout, while tracking the minimum-energy result and an
// all-units-finished flag.
//
// Configuration macro: FIND_COLLECT_TIMESTAMP_EN adds a 32-bit cycle counter,
// a per-capture timestamp in each FIFO entry and the o_res_cycles port.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_seq, i_e, i_done       packed per-unit results and done levels
//   o_res_valid/i_res_ready  FIFO head handshake (pop on valid & ready)
//   o_res_seq/e/unit         FIFO head entry
//   o_fifo_count             FIFO occupancy
//   o_best_*                 minimum-energy result serviced so far
//   o_all_done               every unit finished and nothing left pending
//   o_overrun                sticky: unit re-completed before being serviced
//   o_res_cycles             head entry capture timestamp (macro only)
// -----------------------------------------------------------------------------
module find_collect
  import find_collect_pkg::*;
#(
  parameter int SEQ_WIDTH      = 8,
  parameter int E_WIDTH        = 16,
  parameter int PARALLEL_UNITS = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [PARALLEL_UNITS*SEQ_WIDTH-1:0] i_seq,
  input  logic [PARALLEL_UNITS*E_WIDTH-1:0]   i_e,
  input  logic [PARALLEL_UNITS-1:0]           i_done,
  output logic                                o_res_valid,
  input  logic                                i_res_ready,
  output logic [SEQ_WIDTH-1:0]                o_res_seq,
  output logic [E_WIDTH-1:0]                  o_res_e,
  output logic [$clog2(PARALLEL_UNITS)-1:0]   o_res_unit,
  output logic [$clog2(FIFO_DEPTH):0]         o_fifo_count,
  output logic                                o_best_valid,
  output logic [SEQ_WIDTH-1:0]                o_best_seq,
  output logic [E_WIDTH-1:0]                  o_best_e,
  output logic [$clog2(PARALLEL_UNITS)-1:0]   o_best_unit,
  output logic                                o_all_done,
`ifdef FIND_COLLECT_TIMESTAMP_EN
  output logic [TS_W-1:0]                     o_res_cycles,
`endif
  output logic                                o_overrun
);

  localparam int UNIT_W   = $clog2(PARALLEL_UNITS);
  localparam int ENTRY_W  = entry_width(UNIT_W, E_WIDTH, SEQ_WIDTH);
  localparam int OFF_E    = SEQ_WIDTH;
  localparam int OFF_UNIT = SEQ_WIDTH + E_WIDTH;
`ifdef FIND_COLLECT_TIMESTAMP_EN
  localparam int OFF_TS   = OFF_UNIT + UNIT_W;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PARALLEL_UNITS-1:0]                done_prev_q, done_prev_d;
  logic [PARALLEL_UNITS-1:0][SEQ_WIDTH-1:0] cap_seq_q,   cap_seq_d;
  logic [PARALLEL_UNITS-1:0][E_WIDTH-1:0]   cap_e_q,     cap_e_d;
  logic [PARALLEL_UNITS-1:0]                pending_q,   pending_d;
  logic [PARALLEL_UNITS-1:0]                seen_q,      seen_d;
  logic [UNIT_W-1:0]                        ptr_q,       ptr_d;
  logic                                     best_valid_q, best_valid_d;
  logic [SEQ_WIDTH-1:0]                     best_seq_q,  best_seq_d;
  logic [E_WIDTH-1:0]                       best_e_q,    best_e_d;
  logic [UNIT_W-1:0]                        best_unit_q, best_unit_d;
  logic                                     all_done_q,  all_done_d;
  logic                                     overrun_q,   overrun_d;
`ifdef FIND_COLLECT_TIMESTAMP_EN
  logic [TS_W-1:0]                          cyc_q,       cyc_d;
  logic [PARALLEL_UNITS-1:0][TS_W-1:0]      cap_ts_q,    cap_ts_d;
`endif

  // ---------------------------------------------------------------------------
  // Combinational
  // ---------------------------------------------------------------------------
  logic [PARALLEL_UNITS-1:0] rise;
  logic [PARALLEL_UNITS-1:0] svc_mask;
  scan_act_e                 scan_act;
  logic                      push;
  logic [ENTRY_W-1:0]        push_data;
  logic [ENTRY_W-1:0]        head_data;
  logic                      fifo_empty, fifo_full;

  assign rise = i_done & ~done_prev_q;

  always_comb begin
    scan_act = SCAN_SKIP;
    if (pending_q[ptr_q]) scan_act = fifo_full ? SCAN_STALL : SCAN_PUSH;
  end

  assign push = (scan_act == SCAN_PUSH);

`ifdef FIND_COLLECT_TIMESTAMP_EN
  assign push_data = {cap_ts_q[ptr_q], ptr_q, cap_e_q[ptr_q], cap_seq_q[ptr_q]};
`else
  assign push_data = {ptr_q, cap_e_q[ptr_q], cap_seq_q[ptr_q]};
`endif

  always_comb begin
    svc_mask = '0;
    if (push) svc_mask[ptr_q] = 1'b1;
  end

  always_comb begin
    done_prev_d  = i_done;
    cap_seq_d    = cap_seq_q;
    cap_e_d      = cap_e_q;
    seen_d       = seen_q | rise;
    ptr_d        = ptr_q;
    best_valid_d = best_valid_q;
    best_seq_d   = best_seq_q;
    best_e_d     = best_e_q;
    best_unit_d  = best_unit_q;
`ifdef FIND_COLLECT_TIMESTAMP_EN
    cyc_d        = cyc_q + 1'b1;
    cap_ts_d     = cap_ts_q;
`endif

    for (int k = 0; k < PARALLEL_UNITS; k++) begin
      if (rise[k]) begin
        cap_seq_d[k] = i_seq[k*SEQ_WIDTH +: SEQ_WIDTH];
        cap_e_d[k]   = i_e[k*E_WIDTH +: E_WIDTH];
`ifdef FIND_COLLECT_TIMESTAMP_EN
        // Stamp with the value the counter holds in the cycle the capture
        // becomes visible.
        cap_ts_d[k]  = cyc_d;
`endif
      end
    end

    // Service clears, a new rise sets; set wins so a same-cycle re-completion
    // is picked up on a later visit (the old capture goes out now).
    pending_d = (pending_q & ~svc_mask) | rise;

    // A rise on a unit being serviced this very cycle loses no data.
    overrun_d = overrun_q | (|(rise & pending_q & ~svc_mask));

    if (scan_act != SCAN_STALL) begin
      ptr_d = (ptr_q == UNIT_W'(PARALLEL_UNITS-1)) ? '0 : ptr_q + 1'b1;
    end

    // Strict compare: on a tie the first result serviced stays best.
    if (push && (!best_valid_q || (cap_e_q[ptr_q] < best_e_q))) begin
      best_valid_d = 1'b1;
      best_seq_d   = cap_seq_q[ptr_q];
      best_e_d     = cap_e_q[ptr_q];
      best_unit_d  = ptr_q;
    end

    // Sticky until reset.
    all_done_d = all_done_q | ((&seen_q) & ~(|pending_q));
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      done_prev_q  <= '0;
      cap_seq_q    <= '0;
      cap_e_q      <= '0;
      pending_q    <= '0;
      seen_q       <= '0;
      ptr_q        <= '0;
      best_valid_q <= 1'b0;
      best_seq_q   <= '0;
      best_e_q     <= '0;
      best_unit_q  <= '0;
      all_done_q   <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef FIND_COLLECT_TIMESTAMP_EN
      cyc_q        <= '0;
      cap_ts_q     <= '0;
`endif
    end else begin
      done_prev_q  <= done_prev_d;
      cap_seq_q    <= cap_seq_d;
      cap_e_q      <= cap_e_d;
      pending_q    <= pending_d;
      seen_q       <= seen_d;
      ptr_q        <= ptr_d;
      best_valid_q <= best_valid_d;
      best_seq_q   <= best_seq_d;
      best_e_q     <= best_e_d;
      best_unit_q  <= best_unit_d;
      all_done_q   <= all_done_d;
      overrun_q    <= overrun_d;
`ifdef FIND_COLLECT_TIMESTAMP_EN
      cyc_q        <= cyc_d;
      cap_ts_q     <= cap_ts_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Result FIFO
  // ---------------------------------------------------------------------------
  find_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (i_res_ready),
    .head_data (head_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (o_fifo_count)
  );

  assign o_res_valid  = ~fifo_empty;
  assign o_res_seq    = head_data[0 +: SEQ_WIDTH];
  assign o_res_e      = head_data[OFF_E +: E_WIDTH];
  assign o_res_unit   = head_data[OFF_UNIT +: UNIT_W];
`ifdef FIND_COLLECT_TIMESTAMP_EN
  assign o_res_cycles = head_data[OFF_TS +: TS_W];
`endif

  assign o_best_valid = best_valid_q;
  assign o_best_seq   = best_seq_q;
  assign o_best_e     = best_e_q;
  assign o_best_unit  = best_unit_q;
  assign o_all_done   = all_done_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_find_collect.sv
// -----------------------------------------------------------------------------
// tb_find_collect
// Directed bench for find_collect (4 units, 8-bit seq, 16-bit energy, depth 4).
// Expected FIFO entries are queued when a completion is driven and compared
// whenever the DUT pops its head. Define FIND_COLLECT_TIMESTAMP_EN for both
// bench and RTL to include the timestamp step.
// -----------------------------------------------------------------------------
module tb_find_collect;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_seq;
  logic [63:0] i_e;
  logic [3:0]  i_done;
  logic        i_res_ready;
  logic        o_res_valid;
  logic [7:0]  o_res_seq;
  logic [15:0] o_res_e;
  logic [1:0]  o_res_unit;
  logic [2:0]  o_fifo_count;
  logic        o_best_valid;
  logic [7:0]  o_best_seq;
  logic [15:0] o_best_e;
  logic [1:0]  o_best_unit;
  logic        o_all_done;
  logic        o_overrun;
`ifdef FIND_COLLECT_TIMESTAMP_EN
  logic [31:0] o_res_cycles;
`endif

  find_collect #(
    .SEQ_WIDTH      (8),
    .E_WIDTH        (16),
    .PARALLEL_UNITS (4),
    .FIFO_DEPTH     (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_seq        (i_seq),
    .i_e          (i_e),
    .i_done       (i_done),
    .o_res_valid  (o_res_valid),
    .i_res_ready  (i_res_ready),
    .o_res_seq    (o_res_seq),
    .o_res_e      (o_res_e),
    .o_res_unit   (o_res_unit),
    .o_fifo_count (o_fifo_count),
    .o_best_valid (o_best_valid),
    .o_best_seq   (o_best_seq),
    .o_best_e     (o_best_e),
    .o_best_unit  (o_best_unit),
    .o_all_done   (o_all_done),
`ifdef FIND_COLLECT_TIMESTAMP_EN
    .o_res_cycles (o_res_cycles),
`endif
    .o_overrun    (o_overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  unit;
    logic [15:0] e;
    logic [7:0]  seq;
  } entry_t;

  entry_t sb_q[$];
  int     n_total = 0;
  int     n_pass  = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock: sample the pop handshake on the falling edge, then advance to
  // 1 time unit past the rising edge where the next stimulus is driven.
  task automatic tick();
    entry_t exp_e;
    @(negedge clk);
    if (o_res_valid && i_res_ready) begin
      check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        exp_e = sb_q.pop_front();
        check("pop_entry", 64'({o_res_unit, o_res_e, o_res_seq}), 64'(exp_e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    i_done      = '0;
    i_res_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic raise(input int k, input logic [7:0] s, input logic [15:0] e);
    i_seq[k*8 +: 8]   = s;
    i_e[k*16 +: 16]   = e;
    i_done[k]         = 1'b1;
  endtask

  task automatic expect_entry(input int k, input logic [7:0] s,
                              input logic [15:0] e);
    entry_t x;
    x.unit = 2'(k);
    x.e    = e;
    x.seq  = s;
    sb_q.push_back(x);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && sb_q.size() != 0; i++) tick();
    check(tag, 64'(sb_q.size()), 64'd0);
  endtask

  task automatic check_best(input string tag, input int k,
                            input logic [7:0] s, input logic [15:0] e);
    check(tag, 64'({o_best_valid, o_best_unit, o_best_e, o_best_seq}),
          64'({1'b1, 2'(k), e, s}));
  endtask

  initial begin
    int n;
    i_seq = '0;
    i_e   = '0;

    // ---- 1: reset state, single completion on unit 2 ----
    do_reset();
    check("rst_valid",    64'(o_res_valid),  64'd0);
    check("rst_count",    64'(o_fifo_count), 64'd0);
    check("rst_head",     64'({o_res_unit, o_res_e, o_res_seq}), 64'd0);
    check("rst_best",     64'({o_best_valid, o_best_unit, o_best_e, o_best_seq}), 64'd0);
    check("rst_all_done", 64'(o_all_done),   64'd0);
    check("rst_overrun",  64'(o_overrun),    64'd0);

    i_res_ready = 1'b1;
    raise(2, 8'hA5, 16'h0030);
    expect_entry(2, 8'hA5, 16'h0030);
    n = 0;
    while (!o_res_valid && n < 6) begin
      tick();
      n++;
    end
    check("t1_latency_valid", 64'(o_res_valid), 64'd1);
    drain("t1_drain", 8);
    check_best("t1_best", 2, 8'hA5, 16'h0030);
    ticks(4);
    check("t1_all_done", 64'(o_all_done), 64'd0);

    // ---- 2: all four complete together, tie keeps unit 1 ----
    do_reset();
    i_res_ready = 1'b1;
    ticks(3);  // capture lands when the scanner points at unit 0
    raise(0, 8'h10, 16'd40);
    raise(1, 8'h11, 16'd12);
    raise(2, 8'h12, 16'd12);
    raise(3, 8'h13, 16'd90);
    for (int k = 0; k < 4; k++) expect_entry(k, 8'(8'h10 + k), (k == 0) ? 16'd40 :
                                               (k == 3) ? 16'd90 : 16'd12);
    drain("t2_drain", 12);
    check_best("t2_best", 1, 8'h11, 16'd12);
    n = 0;
    while (!o_all_done && n < 8) begin
      tick();
      n++;
    end
    check("t2_all_done", 64'(o_all_done), 64'd1);

    // ---- 3: backpressure, stall and overrun on unit 0 ----
    do_reset();
    ticks(3);
    raise(0, 8'hA0, 16'd40);
    raise(1, 8'hA1, 16'd50);
    raise(2, 8'hA2, 16'd60);
    raise(3, 8'hA3, 16'd70);
    expect_entry(0, 8'hA0, 16'd40);
    expect_entry(1, 8'hA1, 16'd50);
    expect_entry(2, 8'hA2, 16'd60);
    expect_entry(3, 8'hA3, 16'd70);
    ticks(2);
    i_done[0] = 1'b0;
    tick();
    raise(0, 8'hB0, 16'd1);  // overwritten before service, never pushed
    ticks(2);
    i_done[0] = 1'b0;
    tick();
    raise(0, 8'hC0, 16'd5);
    expect_entry(0, 8'hC0, 16'd5);
    ticks(3);
    check("t3_count_full", 64'(o_fifo_count), 64'd4);
    check("t3_overrun",    64'(o_overrun),    64'd1);
    check("t3_head",       64'({o_res_unit, o_res_e, o_res_seq}),
          64'({2'd0, 16'd40, 8'hA0}));
    check_best("t3_best_stalled", 0, 8'hA0, 16'd40);
    i_res_ready = 1'b1;
    drain("t3_drain", 20);
    ticks(2);
    check_best("t3_best_final", 0, 8'hC0, 16'd5);
    check("t3_count_empty", 64'(o_fifo_count), 64'd0);
    n = 0;
    while (!o_all_done && n < 8) begin
      tick();
      n++;
    end
    check("t3_all_done", 64'(o_all_done), 64'd1);

    // ---- 4: reset while three entries are held ----
    i_res_ready = 1'b0;
    i_done      = '0;
    tick();
    raise(0, 8'hD0, 16'd3);
    raise(1, 8'hD1, 16'd3);
    raise(2, 8'hD2, 16'd3);
    n = 0;
    while (o_fifo_count != 3'd3 && n < 12) begin
      tick();
      n++;
    end
    check("t4_count3", 64'(o_fifo_count), 64'd3);
    do_reset();
    check("t4_count",    64'(o_fifo_count), 64'd0);
    check("t4_valid",    64'(o_res_valid),  64'd0);
    check("t4_best_vld", 64'(o_best_valid), 64'd0);
    check("t4_all_done", 64'(o_all_done),   64'd0);
    check("t4_overrun",  64'(o_overrun),    64'd0);

    // ---- 5: push and pop in the same cycle at count 2 ----
    ticks(3);
    raise(0, 8'h50, 16'd200);
    raise(1, 8'h51, 16'd100);
    raise(2, 8'h52, 16'd300);
    expect_entry(0, 8'h50, 16'd200);
    expect_entry(1, 8'h51, 16'd100);
    expect_entry(2, 8'h52, 16'd300);
    ticks(3);
    check("t5_count_before", 64'(o_fifo_count), 64'd2);
    i_res_ready = 1'b1;
    tick();  // unit 2 pushed while unit 0 pops
    i_res_ready = 1'b0;
    check("t5_count_after", 64'(o_fifo_count), 64'd2);
    check("t5_head", 64'({o_res_unit, o_res_e, o_res_seq}),
          64'({2'd1, 16'd100, 8'h51}));
    i_res_ready = 1'b1;
    drain("t5_drain", 10);
    check_best("t5_best", 1, 8'h51, 16'd100);

`ifdef FIND_COLLECT_TIMESTAMP_EN
    // ---- 6: timestamp of a capture raised in cycle 10 ----
    do_reset();
    ticks(10);
    raise(3, 8'h66, 16'd7);
    expect_entry(3, 8'h66, 16'd7);
    n = 0;
    while (!o_res_valid && n < 10) begin
      tick();
      n++;
    end
    check("t6_valid",  64'(o_res_valid),  64'd1);
    check("t6_cycles", 64'(o_res_cycles), 64'd11);
    i_res_ready = 1'b1;
    drain("t6_drain", 6);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/find_collect.md
Name: find_collect

Overview:
- Sits between the parallel find units and the Wishbone register interface.
- Detects each unit's completion and captures its sequence/energy result.
- Drains results round-robin into a small show-ahead FIFO for software readout.
- Tracks the global minimum-energy result and an all-units-finished flag.

Parameters:
- SEQ_WIDTH, 8, width of one result sequence
- E_WIDTH, 16, width of energy value (unsigned)
- PARALLEL_UNITS, 4, number of find units feeding this block (>=2)
- FIFO_DEPTH, 4, result FIFO entries (power of two, >=2)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset (hard reset OR soft reset)
- i_seq  in  PARALLEL_UNITS*SEQ_WIDTH  unit k's sequence at bits [k*SEQ_WIDTH +: SEQ_WIDTH]
- i_e  in  PARALLEL_UNITS*E_WIDTH  unit k's energy, same packing
- i_done  in  PARALLEL_UNITS  per-unit done level; seq/e valid while high
- o_res_valid  out  1  FIFO not empty
- i_res_ready  in  1  pop request; pop occurs when o_res_valid & i_res_ready
- o_res_seq  out  SEQ_WIDTH  head-entry sequence
- o_res_e  out  E_WIDTH  head-entry energy
- o_res_unit  out  $clog2(PARALLEL_UNITS)  head-entry unit index
- o_fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
- o_best_valid  out  1  at least one result serviced
- o_best_seq  out  SEQ_WIDTH  minimum-energy sequence so far
- o_best_e  out  E_WIDTH  minimum energy so far
- o_best_unit  out  $clog2(PARALLEL_UNITS)  unit index of best result
- o_all_done  out  1  every unit finished and all results serviced
- o_overrun  out  1  sticky: a unit re-completed before its previous result was serviced

Behaviour:
- Single clock, all state synchronous. Reset is synchronous active-high.
- Reset values: all outputs 0; FIFO empty; pending[] = 0; done_q[] = 0; seen[] = 0; scan pointer 0.
- Edge detect: done_q <= i_done every cycle. Rising edge on unit k (i_done[k] & ~done_q[k]) at cycle t causes these updates at edge t+1:
  - cap_seq[k] and cap_e[k] <= inputs
  - pending[k] <= 1
  - seen[k] <= 1
- Rise while pending[k] already set: capture overwrites and o_overrun <= 1.
- Scanner, one unit per cycle, examines pending[ptr]:
  - pending and FIFO not full: push {ptr, cap_e, cap_seq}, update best, clear pending[ptr], ptr <= ptr+1.
  - pending and FIFO full: stall; ptr, pending and best unchanged.
  - not pending: ptr <= ptr+1.
  - ptr wraps from PARALLEL_UNITS-1 to 0.
- Same-cycle service and new rise on the same unit: pending remains 1 (set wins). The serviced data is the old capture; the new capture is serviced on a later visit.
- Service latency: at most PARALLEL_UNITS cycles from capture to push, absent FIFO-full stalls.
- Best update on push: replace if !o_best_valid or cap_e < o_best_e (unsigned strict compare). Ties keep the incumbent (first serviced wins). Best outputs register one cycle after the push decision.
- FIFO behaviour:
  - Push data is visible on o_res_* the cycle after push, when previously empty.
  - Head data is combinational from storage (show-ahead).
  - Full test uses the registered count, so a push is blocked when full even if a pop happens the same cycle.
  - Simultaneous push and pop when not full: count unchanged.
  - Pop when empty is ignored.
- o_all_done = &seen & ~|pending, registered; drops only on reset.
- Reset mid-operation discards captures, FIFO contents and best.

Optional Feature:
- Macro: FIND_COLLECT_TIMESTAMP_EN.
- Defined:
  - Adds a 32-bit free-running cycle counter (reset 0, wraps at 2^32).
  - The counter value is latched per unit at capture and stored in each FIFO entry.
  - Adds output port o_res_cycles [31:0] carrying the head entry's timestamp; reset 0.
- Undefined: no counter, no port, FIFO entry width unchanged from base.

Decomposition:
- Shared header find_pkg.vh:
  - UNIT_W = $clog2(PARALLEL_UNITS)
  - result entry width = UNIT_W + E_WIDTH + SEQ_WIDTH (+32 when timestamp is enabled)
  - field offsets within the entry
- Sub-module find_result_fifo: parameterised show-ahead synchronous FIFO (DEPTH, WIDTH) with push/pop/count. The scanner and best tracker stay in find_collect.

Test Plan (PARALLEL_UNITS=4, SEQ_WIDTH=8, E_WIDTH=16, FIFO_DEPTH=4, i_res_ready=1 unless stated):
1. Reset, then raise i_done[2] with seq=0xA5, e=0x0030 -> one FIFO entry {unit 2, 0x0030, 0xA5} within 6 cycles; best = unit 2/0x0030; o_all_done stays 0.
2. Raise all four done bits in the same cycle with e = 40, 12, 12, 90 -> four entries in unit order 0,1,2,3; best = unit 1, e=12 (tie kept); o_all_done=1 after the last service.
3. i_res_ready=0, five completions staged: done 0..3 plus unit 0 re-raised (drop then rise) -> FIFO count 4, scanner stalls, o_overrun=1. Set ready=1 -> all remaining pending entries drained; nothing lost except the overwritten unit 0 data.
4. Pulse rst while FIFO holds 3 entries -> next cycle: count 0, o_res_valid=0, o_best_valid=0, o_all_done=0, o_overrun=0.
5. Push and pop same cycle at count 2 -> count stays 2; head advances to the next entry in order.
6. With FIND_COLLECT_TIMESTAMP_EN, release reset at cycle 0 and raise i_done[3] at cycle 10 -> o_res_cycles = 11 on the popped entry.
